// File: rtl/keypad_pkg.sv
// Shared types, key codes and helpers for the 3x4 keypad scanner.
package keypad_pkg;

   localparam int unsigned KEY_W = 4;
   localparam int unsigned ROW_W = 4;
   localparam int unsigned COL_W = 3;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2
   } state_t;

   localparam logic [KEY_W-1:0] KEY_NONE  = 4'd0;
   localparam logic [KEY_W-1:0] KEY_STAR  = 4'd10;
   localparam logic [KEY_W-1:0] KEY_ZERO  = 4'd11;
   localparam logic [KEY_W-1:0] KEY_HASH  = 4'd12;
   localparam logic [ROW_W-1:0] ROW_RESET = 4'b0001;

   // Digits fill rows 0-2 left to right; the bottom row is '*', '0', '#'.
   function automatic logic [KEY_W-1:0] key_code(input logic [1:0] r, input logic [1:0] c);
      logic [KEY_W-1:0] code;
      if (r == 2'd3) begin
         case (c)
            2'd0:    code = KEY_STAR;
            2'd1:    code = KEY_ZERO;
            default: code = KEY_HASH;
         endcase
      end else begin
         code = KEY_W'(r) * 4'd3 + KEY_W'(c) + 4'd1;
      end
      return code;
   endfunction

   function automatic logic [1:0] row_index(input logic [ROW_W-1:0] row);
      logic [1:0] idx;
      case (row)
         4'b0010: idx = 2'd1;
         4'b0100: idx = 2'd2;
         4'b1000: idx = 2'd3;
         default: idx = 2'd0;
      endcase
      return idx;
   endfunction

   function automatic logic [1:0] col_index(input logic [COL_W-1:0] col);
      logic [1:0] idx;
      case (col)
         3'b010:  idx = 2'd1;
         3'b100:  idx = 2'd2;
         default: idx = 2'd0;
      endcase
      return idx;
   endfunction

   function automatic logic is_single(input logic [COL_W-1:0] col);
      return (col != 3'b000) && ((col & (col - 3'd1)) == 3'b000);
   endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running divider producing a one-clk scan tick every SCAN_DIV clocks.
module scan_tick_gen #(
   parameter int unsigned SCAN_DIV = 25000
) (
   input  logic clk,
   input  logic rst,
   output logic o_tick_c
);
   localparam int unsigned     DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

   logic [DIV_W-1:0] r_div;

   always_ff @(posedge clk) begin
      if (rst)                    r_div <= '0;
      else if (r_div == DIV_LAST) r_div <= '0;
      else                        r_div <= r_div + DIV_W'(1);
   end

   assign o_tick_c = (r_div == DIV_LAST);

endmodule

// File: rtl/keypad_scanner.sv
// 3x4 keypad scanner: row scan, 2-FF column sync, press/release debounce, one pulse per press.
// Optional KEYPAD_CELL_ONLY_EN: '*', '0', '#' are debounced but never reported.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int unsigned SCAN_DIV       = 25000,
   parameter int unsigned DEBOUNCE_SCANS = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] key_col,
   output logic [3:0] key_row,
   output logic [3:0] key_data,
   output logic       key_valid,
   output logic       key_held
);
   localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SCANS - 1);

   logic [COL_W-1:0] r_sync1;
   logic [COL_W-1:0] r_sync2;
   state_t           r_state;
   logic [ROW_W-1:0] r_key_row;
   logic [KEY_W-1:0] r_key_data;
   logic             r_key_valid;
   logic             r_key_held;
   logic [CNT_W-1:0] r_cnt;
   logic [COL_W-1:0] r_pat;
   logic [1:0]       r_r;
   logic [1:0]       r_c;

   logic             w_tick;
   state_t           w_nxt_state;
   logic [ROW_W-1:0] w_nxt_row;
   logic [KEY_W-1:0] w_nxt_data;
   logic             w_nxt_valid;
   logic [CNT_W-1:0] w_nxt_cnt;
   logic [COL_W-1:0] w_nxt_pat;
   logic [1:0]       w_nxt_r;
   logic [1:0]       w_nxt_c;
   logic [ROW_W-1:0] w_rot_row;
   logic [KEY_W-1:0] w_code;
   logic             w_report;
   logic             w_cnt_done;

   scan_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
      .clk      (clk),
      .rst      (rst),
      .o_tick_c (w_tick)
   );

   // Two-stage synchroniser for the asynchronous column inputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= key_col;
         r_sync2 <= r_sync1;
      end
   end

   assign w_rot_row  = {r_key_row[2:0], r_key_row[3]};
   assign w_code     = key_code(r_r, r_c);
   assign w_cnt_done = (r_cnt >= CNT_LAST);

`ifdef KEYPAD_CELL_ONLY_EN
   assign w_report = (w_code < KEY_STAR);
`else
   assign w_report = 1'b1;
`endif

   always_comb begin
      w_nxt_state = r_state;
      w_nxt_row   = r_key_row;
      w_nxt_data  = r_key_data;
      w_nxt_valid = 1'b0;
      w_nxt_cnt   = r_cnt;
      w_nxt_pat   = r_pat;
      w_nxt_r     = r_r;
      w_nxt_c     = r_c;
      case (r_state)
         SCAN: begin
            if (w_tick) begin
               // Zero or multi-bit columns (ghosting) just keep the scan moving.
               if (is_single(r_sync2)) begin
                  w_nxt_r     = row_index(r_key_row);
                  w_nxt_c     = col_index(r_sync2);
                  w_nxt_pat   = r_sync2;
                  w_nxt_cnt   = CNT_W'(1);
                  w_nxt_state = DEBOUNCE;
               end else begin
                  w_nxt_row = w_rot_row;
               end
            end
         end
         DEBOUNCE: begin
            if (w_tick) begin
               if (r_sync2 == r_pat) begin
                  if (w_cnt_done) begin
                     w_nxt_state = HELD;
                     w_nxt_cnt   = '0;
                     w_nxt_data  = w_report ? w_code : KEY_NONE;
                     w_nxt_valid = w_report;
                  end else begin
                     w_nxt_cnt = r_cnt + CNT_W'(1);
                  end
               end else begin
                  w_nxt_state = SCAN;
                  w_nxt_row   = w_rot_row;
                  w_nxt_data  = KEY_NONE;
               end
            end
         end
         HELD: begin
            // Any activity on the frozen row restarts the release count.
            if (w_tick) begin
               if (r_sync2 == 3'b000) begin
                  if (w_cnt_done) begin
                     w_nxt_state = SCAN;
                     w_nxt_row   = w_rot_row;
                     w_nxt_data  = KEY_NONE;
                     w_nxt_cnt   = '0;
                  end else begin
                     w_nxt_cnt = r_cnt + CNT_W'(1);
                  end
               end else begin
                  w_nxt_cnt = '0;
               end
            end
         end
         default: begin
            w_nxt_state = SCAN;
            w_nxt_row   = ROW_RESET;
            w_nxt_data  = KEY_NONE;
            w_nxt_cnt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= SCAN;
         r_key_row   <= ROW_RESET;
         r_key_data  <= KEY_NONE;
         r_key_valid <= 1'b0;
         r_key_held  <= 1'b0;
         r_cnt       <= '0;
         r_pat       <= '0;
         r_r         <= '0;
         r_c         <= '0;
      end else begin
         r_state     <= w_nxt_state;
         r_key_row   <= w_nxt_row;
         r_key_data  <= w_nxt_data;
         r_key_valid <= w_nxt_valid;
         r_key_held  <= (w_nxt_state == HELD);
         r_cnt       <= w_nxt_cnt;
         r_pat       <= w_nxt_pat;
         r_r         <= w_nxt_r;
         r_c         <= w_nxt_c;
      end
   end

   assign key_row   = r_key_row;
   assign key_data  = r_key_data;
   assign key_valid = r_key_valid;
   assign key_held  = r_key_held;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: physical keypad model, behavioural reference, per-cycle compare.
`timescale 1ns/1ps
module tb_keypad_scanner;
   localparam int unsigned SCAN_DIV = 4;
   localparam int unsigned DB       = 3;
   localparam int M_SCAN = 0, M_DEB = 1, M_HELD = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] key_col;
   logic [3:0] key_row;
   logic [3:0] key_data;
   logic       key_valid;
   logic       key_held;

   logic       press_en;
   logic [1:0] press_r;
   logic [1:0] press_c;
   logic       ovr_en;
   logic [2:0] ovr_col;

   int n_checks = 0;
   int n_errors = 0;
   int n_pulses = 0;

   // Reference model state
   int         m_div, m_row, m_mode, m_cnt, m_r, m_c;
   logic [2:0] m_s1, m_s2, m_pat;
   int         m_data;
   int         m_valid;
   bit         m_ready = 1'b0;

   keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DB)) dut (
      .clk       (clk),
      .rst       (rst),
      .key_col   (key_col),
      .key_row   (key_row),
      .key_data  (key_data),
      .key_valid (key_valid),
      .key_held  (key_held)
   );

   initial forever #5 clk = ~clk;

   // Physical keypad: a pressed key connects its row drive to its column sense.
   always_comb begin
      if (ovr_en)                          key_col = ovr_col;
      else if (press_en && key_row[press_r]) key_col = 3'b001 << press_c;
      else                                 key_col = 3'b000;
   end

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int model_code(input int r, input int c);
      return (r < 3) ? (3 * r + c + 1) : (10 + c);
   endfunction

   function automatic bit model_reports(input int code);
`ifdef KEYPAD_CELL_ONLY_EN
      return code <= 9;
`else
      return 1'b1;
`endif
   endfunction

   task automatic model_step();
      logic [2:0] col;
      bit         tick;
      int         code;
      if (rst) begin
         m_div = 0; m_row = 0; m_mode = M_SCAN; m_cnt = 0;
         m_s1 = 3'b000; m_s2 = 3'b000; m_pat = 3'b000;
         m_data = 0; m_valid = 0; m_r = 0; m_c = 0;
         m_ready = 1'b1;
      end else if (m_ready) begin
         tick  = (m_div == SCAN_DIV - 1);
         m_div = tick ? 0 : m_div + 1;
         col   = m_s2;
         m_s2  = m_s1;
         m_s1  = key_col;
         m_valid = 0;
         if (tick) begin
            if (m_mode == M_SCAN) begin
               if ($countones(col) == 1) begin
                  m_r = m_row;
                  for (int i = 0; i < 3; i++) if (col[i]) m_c = i;
                  m_pat = col; m_cnt = 1; m_mode = M_DEB;
               end else begin
                  m_row = (m_row + 1) % 4;
               end
            end else if (m_mode == M_DEB) begin
               if (col == m_pat) begin
                  m_cnt++;
                  if (m_cnt == DB) begin
                     code   = model_code(m_r, m_c);
                     m_mode = M_HELD; m_cnt = 0;
                     m_data  = model_reports(code) ? code : 0;
                     m_valid = model_reports(code) ? 1 : 0;
                  end
               end else begin
                  m_mode = M_SCAN; m_row = (m_row + 1) % 4; m_data = 0;
               end
            end else begin
               if (col == 3'b000) begin
                  m_cnt++;
                  if (m_cnt == DB) begin
                     m_mode = M_SCAN; m_row = (m_row + 1) % 4; m_data = 0; m_cnt = 0;
                  end
               end else begin
                  m_cnt = 0;
               end
            end
         end
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   // Per-cycle compare against the model, away from the active edge.
   initial begin
      logic prev_valid;
      prev_valid = 1'b0;
      forever begin
         @(negedge clk);
         if (m_ready) begin
            chk("key_row",   key_row,   1 << m_row);
            chk("key_data",  key_data,  m_data);
            chk("key_valid", key_valid, m_valid);
            chk("key_held",  key_held,  (m_mode == M_HELD) ? 1 : 0);
            chk("valid_not_consecutive", int'(key_valid && prev_valid), 0);
            if (key_valid) n_pulses++;
            prev_valid = key_valid;
         end
      end
   end

   task automatic press(input int r, input int c);
      press_en = 1'b1; press_r = 2'(r); press_c = 2'(c);
   endtask

   task automatic release_key();
      press_en = 1'b0;
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_mode(input string name, input int mode);
      for (int i = 0; i < 80 && m_mode != mode; i++) @(negedge clk);
      chk(name, m_mode, mode);
   endtask

   task automatic reset_pulse();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_row",   key_row,   4'b0001);
      chk("rst_data",  key_data,  0);
      chk("rst_valid", key_valid, 0);
      chk("rst_held",  key_held,  0);
   endtask

   initial begin
      int   p0;
      logic [3:0] seen;
      rst = 1'b1; press_en = 1'b0; press_r = 2'd0; press_c = 2'd0;
      ovr_en = 1'b0; ovr_col = 3'b000;
      wait_clk(3);
      chk("init_row",  key_row,  4'b0001);
      chk("init_data", key_data, 0);
      chk("init_held", key_held, 0);
      rst = 1'b0;

      // Idle scan: first rotation on the fourth clock after reset.
      p0 = n_pulses;
      wait_clk(3);
      chk("idle_row_t3", key_row, 4'b0001);
      wait_clk(1);
      chk("idle_row_t4", key_row, 4'b0010);
      seen = '0;
      for (int i = 0; i < 36; i++) begin
         @(negedge clk);
         seen |= key_row;
      end
      chk("idle_rows_seen", seen, 4'hF);
      chk("idle_pulses", n_pulses - p0, 0);
      chk("idle_data", key_data, 0);

      // Row1/col2 press held for 30 ticks.
      p0 = n_pulses;
      press(1, 2);
      wait_clk(30 * SCAN_DIV);
      chk("k6_pulses", n_pulses - p0, 1);
      chk("k6_data",   key_data, 6);
      chk("k6_held",   key_held, 1);
      chk("k6_row",    key_row,  4'b0010);
      release_key();
      wait_clk(24);
      chk("k6_rel_data", key_data, 0);
      chk("k6_rel_held", key_held, 0);
      chk("k6_rel_pulses", n_pulses - p0, 1);

      // Bouncing contact: alternate every tick period, then settle.
      p0 = n_pulses;
      for (int i = 0; i < 4; i++) begin
         press(1, 2);
         wait_clk(SCAN_DIV);
         release_key();
         wait_clk(SCAN_DIV);
      end
      chk("bounce_no_pulse", n_pulses - p0, 0);
      press(1, 2);
      wait_clk(60);
      chk("bounce_one_pulse", n_pulses - p0, 1);
      chk("bounce_data", key_data, 6);
      release_key();
      wait_clk(40);
      chk("bounce_rel_data", key_data, 0);

      // '*' key.
      p0 = n_pulses;
      press(3, 0);
      wait_clk(60);
`ifdef KEYPAD_CELL_ONLY_EN
      chk("star_pulses", n_pulses - p0, 0);
      chk("star_data",   key_data, 0);
`else
      chk("star_pulses", n_pulses - p0, 1);
      chk("star_data",   key_data, 10);
`endif
      chk("star_held", key_held, 1);
      release_key();
      wait_clk(40);
      chk("star_rel_held", key_held, 0);

      // Ghosting: two columns at once is no press.
      p0 = n_pulses;
      ovr_en = 1'b1; ovr_col = 3'b011;
      seen = '0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         seen |= key_row;
      end
      chk("ghost_pulses", n_pulses - p0, 0);
      chk("ghost_held", key_held, 0);
      chk("ghost_rows_seen", seen, 4'hF);
      ovr_en = 1'b0;
      wait_clk(20);

      // Reset mid-DEBOUNCE, then a fresh debounce must complete.
      press(0, 0);
      wait_mode("reach_debounce", M_DEB);
      reset_pulse();
      p0 = n_pulses;
      wait_clk(10);
      chk("deb_rst_no_early_pulse", n_pulses - p0, 0);
      wait_clk(60);
      chk("deb_rst_fresh_pulse", n_pulses - p0, 1);
      chk("deb_rst_data", key_data, 1);

      // Reset mid-HELD with the key still down.
      chk("pre_rst_held", key_held, 1);
      reset_pulse();
      p0 = n_pulses;
      wait_clk(10);
      chk("held_rst_no_early_pulse", n_pulses - p0, 0);
      release_key();
      wait_clk(40);

      // Randomised traffic against the model.
      for (int it = 0; it < 150; it++) begin
         int sel;
         sel = int'($urandom_range(0, 9));
         if (sel == 0) begin
            ovr_en  = 1'b1;
            ovr_col = 3'($urandom_range(0, 7));
         end else if (sel == 1) begin
            rst = 1'b1;
         end else if (sel <= 3) begin
            ovr_en = 1'b0;
            release_key();
         end else begin
            ovr_en = 1'b0;
            press(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
         end
         wait_clk((sel == 1) ? 1 : int'($urandom_range(1, 60)));
         rst = 1'b0;
      end
      ovr_en = 1'b0;
      release_key();
      wait_clk(40);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion at %0t", $time);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Upstream stage of gameState: scans the 3x4 matrix keypad, synchronises and debounces it, and emits one code per physical press.
- gameState consumes key_data/key_valid to place O/X on board cells 1-9.
- Replaces the raw level-driven key_data path with a clean one-cycle event.

Parameters:
- SCAN_DIV, 25000, clk cycles per scan tick (tick when divider == SCAN_DIV-1).
- DEBOUNCE_SCANS, 4, consecutive identical scan-tick samples required for press and for release.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; synchronous, active-high.
- key_col  input  3  keypad column sense; active-high, asynchronous to clk.
- key_row  output  4  row drive; one-hot, active-high.
- key_data  output  4  code of the current key: 0 none, 1-9 digits, 10 '*', 11 '0', 12 '#'.
- key_valid  output  1  one-clk pulse when a debounced press is accepted.
- key_held  output  1  high while the FSM is in HELD.

Behaviour:
- Reset values (any state, including mid-DEBOUNCE/HELD): key_row=4'b0001, key_data=0, key_valid=0, key_held=0, state=SCAN, divider=0, debounce count=0. No pulse is emitted during or after reset.
- key_col passes through a 2-FF synchroniser. Only the synchronised value is used, sampled on scan-tick clocks.
- Divider counts 0..SCAN_DIV-1, wraps, and asserts tick for one clk at SCAN_DIV-1.
- SCAN state, on tick:
  - Sampled col has exactly one bit set: latch row index r, col index c, and the pattern; freeze key_row; count=1; go to DEBOUNCE.
  - Col is zero or has multiple bits set (ghosting): rotate key_row 0001->0010->0100->1000->0001.
- DEBOUNCE state, on tick:
  - Pattern equals latched pattern: count++.
  - When count reaches DEBOUNCE_SCANS: key_data = code(r,c), key_valid=1 for exactly that clk, go to HELD.
  - Pattern differs: go to SCAN, rotate row, key_data stays 0.
- HELD state:
  - key_held=1, row frozen, key_data holds the code.
  - On tick: col==0 increments the release count; any nonzero col clears it.
  - Release count reaches DEBOUNCE_SCANS: key_data=0, go to SCAN, rotate row.
  - No further key_valid until a new press is accepted. Other keys pressed during HELD are ignored.
- Code mapping:
  - r<3: code = 3r+c+1.
  - r=3: c=0->10, c=1->11, c=2->12.
- Latency: a stable press is reported within 2 clk (sync) + at most 4 ticks (row search) + DEBOUNCE_SCANS-1 ticks.
- key_valid never asserts on two consecutive clks.
- key_valid and the new key_data appear on the same clk edge.

Optional Feature:
- Macro KEYPAD_CELL_ONLY_EN.
- Defined: codes 10-12 are debounced and enter HELD (release still required), but key_valid stays 0 and key_data stays 0 for them. Only board cells 1-9 reach gameState.
- Undefined: all 12 codes reported as above.

Decomposition:
- Package keypad_pkg:
  - state enum {SCAN, DEBOUNCE, HELD}.
  - constants KEY_NONE=0, KEY_STAR=10, KEY_ZERO=11, KEY_HASH=12, ROW_RESET=4'b0001.
  - function mapping (r,c) to code.
- One sub-module, scan_tick_gen: a parameterised SCAN_DIV divider with synchronous active-high rst and a single-cycle tick output.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=3):
- After rst, hold key_col=0 for 40 clk -> key_row cycles 0001,0010,0100,1000 every 4 clk; key_valid never asserts; key_data=0.
- Press the row1/col2 key (col=3'b100 only while key_row==0010), hold for 30 ticks -> exactly one key_valid pulse, key_data=6, key_held=1 and key_row frozen at 0010 until release.
- Same key bounces: toggles at ticks 1 and 2, then stable -> no pulse during bounce, exactly one pulse after 3 stable ticks. Release -> key_data=0 after 3 zero ticks, then rotation resumes.
- Row3/col0 ('*') press -> without macro: key_data=10 with pulse. With KEYPAD_CELL_ONLY_EN: no pulse, key_data=0, key_held=1 until release.
- Two columns asserted together (3'b011) -> treated as no press: no pulse, rotation continues.
- Assert rst for 1 clk mid-DEBOUNCE and mid-HELD -> next clk all outputs at reset values; no key_valid pulse until a fresh full debounce.
